// File: rtl/node_layer_seq.sv
// Sequential fully-connected layer: one MAC per cycle, one neuron at a time.
// A buffered input vector is multiplied against weight-ROM rows; each neuron
// adds its bias, is rescaled from the product Q format, saturated and
// optionally ReLU'd, then emitted with a valid/ready handshake.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid/in_ready     input vector handshake, in_data packed N_IN x DW
//   w_addr/w_data         weight ROM (data one cycle after address)
//   b_addr/b_data         bias ROM (data one cycle after address)
//   out_valid/out_ready   result handshake with out_data, out_idx, out_last
//   busy                  high whenever a vector is in flight
module node_layer_seq #(
  parameter int unsigned N_IN    = 16,
  parameter int unsigned M_OUT   = 16,
  parameter int unsigned DW      = 16,
  parameter int unsigned FRAC    = 8,
  parameter int unsigned RELU_EN = 1,
  localparam int unsigned AW     = ($clog2(M_OUT * N_IN) < 1) ? 1 : $clog2(M_OUT * N_IN),
  localparam int unsigned MW     = ($clog2(M_OUT) < 1) ? 1 : $clog2(M_OUT)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N_IN*DW-1:0]   in_data,
  output logic [AW-1:0]        w_addr,
  input  logic [DW-1:0]        w_data,
  output logic [MW-1:0]        b_addr,
  input  logic [DW-1:0]        b_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DW-1:0]        out_data,
  output logic [MW-1:0]        out_idx,
  output logic                 out_last,
  output logic                 busy
);

  localparam int unsigned ACC_W = 2 * DW + $clog2(N_IN) + 1;
  localparam int unsigned JW    = ($clog2(N_IN) < 1) ? 1 : $clog2(N_IN);

  typedef enum logic [1:0] {IDLE, MAC, DRAIN, EMIT} state_t;

  state_t                  state, state_d;
  logic [DW-1:0]           vbuf [N_IN];
  logic [JW-1:0]           j, j_d;
  logic                    mac_d;
  logic [MW-1:0]           m;
  logic signed [ACC_W-1:0] acc, acc_sum_c;
  logic signed [2*DW-1:0]  prod_c;
  logic signed [ACC_W:0]   bias_c, s_c, r_c, sat_max_c, sat_min_c;
  logic [DW-1:0]           res_c;
  logic                    accept_c, hs_c, last_j_c, last_m_c;

  // Next-state logic and handshake strobes
  always_comb begin
    state_d  = state;
    accept_c = 1'b0;
    hs_c     = 1'b0;
    last_j_c = (j == JW'(N_IN - 1));
    last_m_c = (m == MW'(M_OUT - 1));
    case (state)
      IDLE: if (in_valid) begin
        accept_c = 1'b1;
        state_d  = MAC;
      end
      MAC:   if (last_j_c) state_d = DRAIN;
      DRAIN: state_d = EMIT;
      EMIT: if (out_ready) begin
        hs_c    = 1'b1;
        state_d = last_m_c ? IDLE : MAC;
      end
      default: state_d = IDLE;
    endcase
  end

  // Product of the weight returned this cycle with the element addressed last cycle
  always_comb begin
    prod_c    = (2*DW)'($signed(w_data)) * (2*DW)'($signed(vbuf[j_d]));
    acc_sum_c = acc + ACC_W'(prod_c);
    bias_c    = (ACC_W+1)'($signed(b_data)) <<< FRAC;
    s_c       = (ACC_W+1)'(acc_sum_c) + bias_c;
    r_c       = s_c >>> FRAC;
    sat_max_c = '0;
    sat_max_c[DW-2:0] = '1;
    sat_min_c = '1;
    sat_min_c[DW-2:0] = '0;
    if (r_c > sat_max_c)      res_c = sat_max_c[DW-1:0];
    else if (r_c < sat_min_c) res_c = sat_min_c[DW-1:0];
    else                      res_c = r_c[DW-1:0];
    if ((RELU_EN != 0) && r_c[ACC_W]) res_c = '0;
  end

  // State register and datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      for (int i = 0; i < int'(N_IN); i++) vbuf[i] <= '0;
      j         <= '0;
      j_d       <= '0;
      mac_d     <= 1'b0;
      m         <= '0;
      acc       <= '0;
      w_addr    <= '0;
      b_addr    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      state    <= state_d;
      busy     <= (state_d != IDLE);
      in_ready <= (state_d == IDLE);
      mac_d    <= (state == MAC);
      j_d      <= j;
      if (mac_d) acc <= acc_sum_c;
      case (state)
        IDLE: if (accept_c) begin
          for (int i = 0; i < int'(N_IN); i++) vbuf[i] <= in_data[i*DW +: DW];
          m      <= '0;
          acc    <= '0;
          j      <= '0;
          w_addr <= '0;
          b_addr <= '0;
        end
        // Address stays on the last element so a stalled EMIT issues nothing new
        MAC: if (!last_j_c) begin
          j      <= j + JW'(1);
          w_addr <= w_addr + AW'(1);
        end
        DRAIN: begin
          out_valid <= 1'b1;
          out_data  <= res_c;
          out_idx   <= m;
          out_last  <= last_m_c;
        end
        EMIT: if (hs_c) begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          if (!last_m_c) begin
            m      <= m + MW'(1);
            acc    <= '0;
            j      <= '0;
            w_addr <= w_addr + AW'(1);
            b_addr <= m + MW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/node_layer_seq.md
NODE_LAYER_SEQ -- requirements
Module: node_layer_seq

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  N_IN, 16, inputs per neuron (>=2).
  M_OUT, 16, neurons in the layer (>=1).
  DW, 16, signed data, weight and bias width.
  FRAC, 8, fractional bits of the Q format shared by data, weights and biases.
  RELU_EN, 1, 1 = clamp negative results to 0.
REQ-002 Derived widths SHALL be: AW = max(1, clog2(M_OUT*N_IN)); MW = max(1, clog2(M_OUT)); ACC_W = 2*DW + clog2(N_IN) + 1.
REQ-003 Ports SHALL be, one per line: name  direction  width  meaning.
  clk  in  1  single clock; all state on rising edge.
  rst_n  in  1  asynchronous, active-low reset.
  in_valid  in  1  input vector valid.
  in_ready  out  1  block can accept a vector.
  in_data  in  N_IN*DW  packed signed inputs; element j at bits [j*DW +: DW].
  w_addr  out  AW  weight ROM address = m*N_IN + j.
  w_data  in  DW  signed weight; valid one cycle after w_addr.
  b_addr  out  MW  bias ROM address = m.
  b_data  in  DW  signed bias; valid one cycle after b_addr.
  out_valid  out  1  neuron result valid.
  out_ready  in  1  downstream accepts result.
  out_data  out  DW  signed saturated (optionally ReLU'd) result.
  out_idx  out  MW  neuron index m of out_data.
  out_last  out  1  high with out_valid when m = M_OUT-1.
  busy  out  1  high in any state other than IDLE.

Function
REQ-004 FSM SHALL have states IDLE, MAC, DRAIN, EMIT.
REQ-005 in_ready SHALL equal (state == IDLE); in_valid outside IDLE SHALL be ignored.
REQ-006 On an edge with in_valid & in_ready: latch all of in_data into an internal buffer, set m = 0, clear accumulator, go to MAC.
REQ-007 In MAC the block SHALL drive w_addr = m*N_IN + j for j = 0..N_IN-1 on consecutive cycles, and drive b_addr = m throughout MAC and DRAIN.
REQ-008 Each w_data SHALL be multiplied with buffered element j (signed DW x DW -> 2*DW) one cycle after its address; the sign-extended product SHALL be added into the ACC_W accumulator, which SHALL never wrap.
REQ-009 After the j = N_IN-1 address cycle the FSM SHALL go to DRAIN for exactly one cycle, which accumulates the final product.
REQ-010 At the DRAIN->EMIT edge, out_data SHALL be registered as: s = acc + (b_data sign-extended << FRAC); r = s >>> FRAC (arithmetic shift, floor); saturate r to [-2^(DW-1), 2^(DW-1)-1]; if RELU_EN and r < 0 then 0.
REQ-011 out_valid SHALL rise N_IN+1 clock edges after the MAC-entry edge and stay high, with out_data, out_idx and out_last stable, until out_valid & out_ready.
REQ-012 On the EMIT handshake edge: if m < M_OUT-1, increment m, clear accumulator and go to MAC; otherwise go to IDLE.
REQ-013 Per-neuron period SHALL be N_IN+2 cycles with out_ready held high; per-vector period SHALL be M_OUT*(N_IN+2) cycles plus 1 accept cycle.
REQ-014 With M_OUT = 1, out_idx SHALL read 0 and out_last SHALL equal out_valid.
REQ-015 Results SHALL be emitted in strictly increasing m, with no skipped or duplicated neurons.

Reset
REQ-016 While rst_n = 0, regardless of clk: state = IDLE, m = 0, accumulator = 0, out_valid = 0, out_data = 0, out_idx = 0, out_last = 0, busy = 0, w_addr = 0, b_addr = 0; in_ready = 1 after release.
REQ-017 Reset asserted mid-vector SHALL abandon the vector; no partial result SHALL be emitted after release.

Verification
REQ-018 Nominal (N_IN=4, M_OUT=2, FRAC=8): inputs all 0x0100, weights all 0x0080, bias 0x0040 -> two results 0x0240, out_idx 0 then 1, out_last on the second only; out_valid 5 edges after MAC entry.
REQ-019 Saturation: inputs and weights all 0x7FFF, bias 0x7FFF -> out_data 0x7FFF; all weights 0x8000, inputs 0x7FFF, RELU_EN=0 -> 0x8000.
REQ-020 ReLU: inputs 0x0100, weights 0xFF80, bias 0x0040 -> 0x0000 with RELU_EN=1; 0xFE40 with RELU_EN=0.
REQ-021 Backpressure: out_ready low for 5 cycles in EMIT -> out_valid, out_data and out_idx held; no new w_addr issued; next neuron starts on the handshake edge.
REQ-022 Busy input: in_valid pulsed during MAC with a different in_data -> ignored; results match the first vector; in_ready = 0 until last handshake.
REQ-023 Reset mid-MAC: rst_n low 2 cycles at j = 2 of neuron 0 -> all outputs at reset values; a fresh vector after release gives the nominal 0x0240 results.
